// File: rtl/melody_sequencer.sv
// Melody sequencer: arbitrates live keypad notes against stored-melody playback
// and can record a live performance into a small note/duration memory.
// Drives the tone generator's note select (hex) and its audio gate (sound_on).
module melody_sequencer #(
    parameter int TICK_CYCLES = 12_500_000,
    parameter int DEPTH       = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_hex,
    input  logic       rec_start,
    input  logic       play_start,
    input  logic       stop,
    input  logic       loop,
    output logic [3:0] hex,
    output logic       sound_on,
    output logic [1:0] state,
    output logic [4:0] song_len,
    output logic       full
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [4:0] LAST_SLOT = 5'(DEPTH - 1);
    localparam logic [3:0] LEN_MAX = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t st;

    // Entry layout: {rest, note[3:0], len[3:0]}
    logic [8:0] mem [DEPTH];

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    // Open recording segment
    logic       seg_open;
    logic       seg_rest;
    logic [3:0] seg_note;
    logic [3:0] seg_len;

    // Playback position
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic [3:0]       play_left;
    logic             last_entry;
    logic [8:0]       next_entry;
    logic [8:0]       first_entry;

    logic       boundary;
    logic       wr_en;
    logic [8:0] wr_data;

    function automatic logic entry_rest(input logic [8:0] e);
        return e[8];
    endfunction

    function automatic logic [3:0] entry_note(input logic [8:0] e);
        return e[7:4];
    endfunction

    function automatic logic [3:0] entry_len(input logic [8:0] e);
        return e[3:0];
    endfunction

    assign state = st;

    // Segment boundary detection, memory write decision and next-entry lookup
    always_comb begin
        tick       = (tick_cnt == TICK_LAST);
        // A rest segment ends when a key goes down; a note segment ends on
        // release or when a different key is now held.
        boundary   = seg_open &&
                     ((key_valid == seg_rest) || (key_valid && (key_hex != seg_note)));
        wr_data    = {seg_rest, seg_note, seg_len};
        wr_en      = 1'b0;
        if (!reset && (st == S_REC) && seg_open) begin
            if (stop)
                wr_en = !seg_rest;
            else if (boundary)
                wr_en = 1'b1;
            else if (tick && (seg_len == LEN_MAX))
                wr_en = 1'b1;
        end
        last_entry  = (5'(idx) == (song_len - 5'd1));
        next_idx    = last_entry ? '0 : idx + 1'b1;
        next_entry  = mem[next_idx];
        first_entry = mem[0];
    end

    // Melody memory; contents are meaningless beyond song_len so no reset
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[song_len[IDX_W-1:0]] <= wr_data;
    end

    // Main controller: mode FSM, registered outputs, tick counter, recorder and player
    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_IDLE;
            hex       <= 4'h0;
            sound_on  <= 1'b0;
            song_len  <= 5'd0;
            full      <= 1'b0;
            tick_cnt  <= '0;
            seg_open  <= 1'b0;
            idx       <= '0;
            play_left <= 4'd0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

            case (st)
                S_IDLE: begin
                    if (key_valid) begin
                        hex      <= key_hex;
                        sound_on <= 1'b1;
                    end else begin
                        sound_on <= 1'b0;
                    end
                    if (stop) begin
                        // stop has nothing to abort here but still outranks the others
                    end else if (rec_start) begin
                        st       <= S_REC;
                        song_len <= 5'd0;
                        full     <= 1'b0;
                        seg_open <= 1'b0;
                    end else if (play_start && (song_len != 5'd0)) begin
                        st        <= S_PLAY;
                        idx       <= '0;
                        hex       <= entry_note(first_entry);
                        sound_on  <= !entry_rest(first_entry);
                        play_left <= entry_len(first_entry);
                        tick_cnt  <= '0;
                    end
                end

                S_REC: begin
                    if (key_valid) begin
                        hex      <= key_hex;
                        sound_on <= 1'b1;
                    end else begin
                        sound_on <= 1'b0;
                    end
                    if (stop) begin
                        st       <= S_IDLE;
                        seg_open <= 1'b0;
                    end else if (!seg_open) begin
                        // Leading silence is skipped: wait for the first key
                        if (key_valid) begin
                            seg_open <= 1'b1;
                            seg_rest <= 1'b0;
                            seg_note <= key_hex;
                            seg_len  <= 4'd1;
                            tick_cnt <= '0;
                        end
                    end else if (boundary) begin
                        seg_rest <= !key_valid;
                        seg_note <= key_valid ? key_hex : 4'h0;
                        seg_len  <= 4'd1;
                        tick_cnt <= '0;
                    end else if (tick) begin
                        // A 15-tick segment is closed and continued as a fresh one
                        if (seg_len == LEN_MAX) begin
                            seg_len  <= 4'd1;
                            tick_cnt <= '0;
                        end else begin
                            seg_len <= seg_len + 4'd1;
                        end
                    end
                end

                S_PLAY: begin
                    if (stop) begin
                        st       <= S_IDLE;
                        sound_on <= 1'b0;
                    end else if (tick) begin
                        if (play_left == 4'd1) begin
                            if (last_entry && !loop) begin
                                st       <= S_IDLE;
                                sound_on <= 1'b0;
                            end else begin
                                idx       <= next_idx;
                                hex       <= entry_note(next_entry);
                                sound_on  <= !entry_rest(next_entry);
                                play_left <= entry_len(next_entry);
                                tick_cnt  <= '0;
                            end
                        end else begin
                            play_left <= play_left - 4'd1;
                        end
                    end
                end

                default: begin
                    st <= S_IDLE;
                end
            endcase

            // Every memory write bumps the length; filling the memory ends recording
            if (wr_en) begin
                song_len <= song_len + 5'd1;
                if (song_len == LAST_SLOT) begin
                    full     <= 1'b1;
                    st       <= S_IDLE;
                    seg_open <= 1'b0;
                end
            end
        end
    end

endmodule
